// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared timing constants and phase type for the traffic light controller slice
// Contents:
//   DEF_CLK_FREQ_HZ, DEF_SHORT_SEC, DEF_LONG_SEC, DEF_SEC_W : default timing parameters
//   tl_phase_e      : controller phase encoding (green/yellow per direction)
//   phase_uses_long : long-phase (green) phases wait on five_sec_timer, others on one_sec_timer
package traffic_light_pkg;

    localparam int unsigned DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DEF_SHORT_SEC   = 1;
    localparam int unsigned DEF_LONG_SEC    = 5;
    localparam int unsigned DEF_SEC_W       = 4;

    typedef enum logic [1:0] {
        PH_NS_GREEN  = 2'd0,
        PH_NS_YELLOW = 2'd1,
        PH_EW_GREEN  = 2'd2,
        PH_EW_YELLOW = 2'd3
    } tl_phase_e;

    function automatic logic phase_uses_long(input tl_phase_e ph);
        return (ph == PH_NS_GREEN) || (ph == PH_EW_GREEN);
    endfunction

endpackage

// File: rtl/traffic_light_timer_if.sv
// rtl/traffic_light_timer_if.sv - controller <-> timer handshake bundle
// Signals:
//   rst_count      : restart request from the controller (controller drives)
//   count_en       : time advances while high (controller drives)
//   one_sec_timer  : short-phase expiry level (timer drives)
//   five_sec_timer : long-phase expiry level (timer drives)
//   sec_tick       : one-cycle pulse per elapsed second (timer drives)
//   sec_count      : elapsed whole seconds, saturating (timer drives)
// Modports: master = controller side, slave = timer side.
interface traffic_light_timer_if #(
    parameter int unsigned SEC_W = traffic_light_pkg::DEF_SEC_W
) ();

    logic             rst_count;
    logic             count_en;
    logic             one_sec_timer;
    logic             five_sec_timer;
    logic             sec_tick;
    logic [SEC_W-1:0] sec_count;

    modport master (
        output rst_count,
        output count_en,
        input  one_sec_timer,
        input  five_sec_timer,
        input  sec_tick,
        input  sec_count
    );

    modport slave (
        input  rst_count,
        input  count_en,
        output one_sec_timer,
        output five_sec_timer,
        output sec_tick,
        output sec_count
    );

endinterface

// File: rtl/traffic_tick_gen.sv
// rtl/traffic_tick_gen.sv - clock prescaler producing a wrap indication once per CLK_FREQ_HZ enabled cycles
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, clears the prescaler
//   clear : synchronous clear, wins over en
//   en    : prescaler advances while high, holds while low
//   tick  : combinational, high in the cycle whose rising edge wraps the prescaler
module traffic_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = traffic_light_pkg::DEF_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned     PS_W   = $clog2(CLK_FREQ_HZ);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_FREQ_HZ - 1);

    logic [PS_W-1:0] prescale_q;
    logic [PS_W-1:0] prescale_d;

    // tick is not gated by clear: the parent decides what a simultaneous
    // restart and wrap means for its own state.
    always_comb begin
        prescale_d = prescale_q;
        tick       = en && (prescale_q == PS_MAX);
        if (clear) begin
            prescale_d = '0;
        end else if (tick) begin
            prescale_d = '0;
        end else if (en) begin
            prescale_d = prescale_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

endmodule

// File: rtl/traffic_light_timer.sv
// rtl/traffic_light_timer.sv - seconds timer with registered short/long expiry levels for the traffic light controller
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   tl    : slave side of traffic_light_timer_if
//           (rst_count, count_en in; one_sec_timer, five_sec_timer, sec_tick, sec_count out)
// All outputs come straight from flops so the controller may derive rst_count
// combinationally from the flags without closing a loop.
module traffic_light_timer
    import traffic_light_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned SHORT_SEC   = DEF_SHORT_SEC,
    parameter int unsigned LONG_SEC    = DEF_LONG_SEC,
    parameter int unsigned SEC_W       = DEF_SEC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_light_timer_if.slave  tl
);

    generate
        if (!((LONG_SEC > SHORT_SEC) && (SHORT_SEC >= 1) && (CLK_FREQ_HZ >= 2) &&
              (LONG_SEC <= ((64'd1 << SEC_W) - 64'd1)))) begin : g_bad_params
            $error("traffic_light_timer: illegal CLK_FREQ_HZ/SHORT_SEC/LONG_SEC/SEC_W combination");
        end
    endgenerate

    localparam logic [SEC_W-1:0] SHORT_V = SEC_W'(SHORT_SEC);
    localparam logic [SEC_W-1:0] LONG_V  = SEC_W'(LONG_SEC);

    logic             wrap;
    logic [SEC_W-1:0] sec_count_q;
    logic [SEC_W-1:0] sec_count_d;
    logic             one_sec_q;
    logic             one_sec_d;
    logic             five_sec_q;
    logic             five_sec_d;
    logic             sec_tick_q;
    logic             sec_tick_d;

    traffic_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (tl.rst_count),
        .en    (tl.count_en),
        .tick  (wrap)
    );

    // Restart beats a coincident wrap: no tick pulse and no carry into the
    // new count. Flags derive from the next count so they move with it.
    always_comb begin
        sec_count_d = sec_count_q;
        sec_tick_d  = 1'b0;
        if (tl.rst_count) begin
            sec_count_d = '0;
        end else if (wrap) begin
            sec_tick_d = 1'b1;
            if (sec_count_q != LONG_V) begin
                sec_count_d = sec_count_q + SEC_W'(1);
            end
        end
        one_sec_d  = (sec_count_d >= SHORT_V);
        five_sec_d = (sec_count_d >= LONG_V);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_count_q <= '0;
            one_sec_q   <= 1'b0;
            five_sec_q  <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            sec_count_q <= sec_count_d;
            one_sec_q   <= one_sec_d;
            five_sec_q  <= five_sec_d;
            sec_tick_q  <= sec_tick_d;
        end
    end

    assign tl.sec_count      = sec_count_q;
    assign tl.one_sec_timer  = one_sec_q;
    assign tl.five_sec_timer = five_sec_q;
    assign tl.sec_tick       = sec_tick_q;

endmodule

// File: tb/tb_traffic_light_timer.sv
// tb/tb_traffic_light_timer.sv - directed self-checking bench for traffic_light_timer
module tb_traffic_light_timer;
    import traffic_light_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_light_timer_if #(.SEC_W(4)) tl_a ();
    traffic_light_timer_if #(.SEC_W(4)) tl_b ();

    traffic_light_timer #(
        .CLK_FREQ_HZ (10),
        .SHORT_SEC   (1),
        .LONG_SEC    (5),
        .SEC_W       (4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .tl    (tl_a)
    );

    traffic_light_timer #(
        .CLK_FREQ_HZ (4),
        .SHORT_SEC   (1),
        .LONG_SEC    (5),
        .SEC_W       (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .tl    (tl_b)
    );

    // {one_sec_timer, five_sec_timer, sec_tick, sec_count}
    logic [6:0] obs_a;
    assign obs_a = {tl_a.one_sec_timer, tl_a.five_sec_timer, tl_a.sec_tick, tl_a.sec_count};

    task automatic restart_from_reset();
        reset = 1'b1;
        tl_a.rst_count = 1'b0;
        tl_a.count_en  = 1'b1;
        tl_b.rst_count = 1'b0;
        tl_b.count_en  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tl_a.rst_count = 1'b0;
        tl_a.count_en  = 1'b1;
        tl_b.rst_count = 1'b0;
        tl_b.count_en  = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_a !== 7'd0) begin
            errors++;
            $display("FAIL reset_a obs=%b want=%b", obs_a, 7'd0);
        end
        vectors++;
        if ({tl_b.one_sec_timer, tl_b.five_sec_timer, tl_b.sec_tick, tl_b.sec_count} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b obs=%b want=%b",
                     {tl_b.one_sec_timer, tl_b.five_sec_timer, tl_b.sec_tick, tl_b.sec_count}, 7'd0);
        end
        reset = 1'b0;
    endtask

    // Free run: one_sec at edge 10, five_sec at edge 50, sec_count saturates at 5.
    task automatic test_free_run();
        logic [6:0] exp;
        int         sc;
        restart_from_reset();
        for (int e = 1; e <= 60; e++) begin
            @(negedge clk);
            sc  = (e / 10 > 5) ? 5 : e / 10;
            exp = {(e >= 10), (e >= 50), (e % 10 == 0), 4'(sc)};
            vectors++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL free_run edge=%0d obs=%b want=%b", e, obs_a, exp);
            end
        end
    endtask

    // rst_count sampled at edge 23: outputs clear, one_sec at 33, five_sec at 73.
    task automatic test_restart();
        logic [6:0] exp;
        int         sc;
        restart_from_reset();
        repeat (22) @(negedge clk);
        tl_a.rst_count = 1'b1;
        @(negedge clk);
        tl_a.rst_count = 1'b0;
        vectors++;
        if (obs_a !== 7'd0) begin
            errors++;
            $display("FAIL restart_clear obs=%b want=%b", obs_a, 7'd0);
        end
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            sc  = (k / 10 > 5) ? 5 : k / 10;
            exp = {(k >= 10), (k >= 50), (k % 10 == 0), 4'(sc)};
            vectors++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL restart edge=%0d obs=%b want=%b", 23 + k, obs_a, exp);
            end
        end
    endtask

    // Restart coincides with the 4->5 wrap and is held for 3 edges.
    task automatic test_collision();
        logic [6:0] exp;
        restart_from_reset();
        repeat (49) @(negedge clk);
        vectors++;
        if (obs_a !== {1'b1, 1'b0, 1'b0, 4'd4}) begin
            errors++;
            $display("FAIL collision_pre obs=%b want=%b", obs_a, {1'b1, 1'b0, 1'b0, 4'd4});
        end
        tl_a.rst_count = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== 7'd0) begin
                errors++;
                $display("FAIL collision_hold cyc=%0d obs=%b want=%b", i, obs_a, 7'd0);
            end
        end
        tl_a.rst_count = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = (k == 10) ? {1'b1, 1'b0, 1'b1, 4'd1} : 7'd0;
            vectors++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL collision_after k=%0d obs=%b want=%b", k, obs_a, exp);
            end
        end
    endtask

    // Freeze edges 5..11 -> one_sec at edge 17; restart during a freeze still clears.
    task automatic test_freeze();
        logic [6:0] exp;
        restart_from_reset();
        repeat (4) @(negedge clk);
        tl_a.count_en = 1'b0;
        for (int e = 5; e <= 11; e++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== 7'd0) begin
                errors++;
                $display("FAIL freeze_hold edge=%0d obs=%b want=%b", e, obs_a, 7'd0);
            end
        end
        tl_a.count_en = 1'b1;
        for (int e = 12; e <= 17; e++) begin
            @(negedge clk);
            exp = (e == 17) ? {1'b1, 1'b0, 1'b1, 4'd1} : 7'd0;
            vectors++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL freeze_resume edge=%0d obs=%b want=%b", e, obs_a, exp);
            end
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (obs_a !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL freeze_pre_rst obs=%b want=%b", obs_a, {1'b1, 1'b0, 1'b0, 4'd1});
        end
        tl_a.count_en  = 1'b0;
        tl_a.rst_count = 1'b1;
        @(negedge clk);
        tl_a.rst_count = 1'b0;
        vectors++;
        if (obs_a !== 7'd0) begin
            errors++;
            $display("FAIL freeze_rst_clear obs=%b want=%b", obs_a, 7'd0);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== 7'd0) begin
                errors++;
                $display("FAIL freeze_rst_hold k=%0d obs=%b want=%b", k, obs_a, 7'd0);
            end
        end
        tl_a.count_en = 1'b1;
        for (int k = 4; k <= 13; k++) begin
            @(negedge clk);
            exp = (k == 13) ? {1'b1, 1'b0, 1'b1, 4'd1} : 7'd0;
            vectors++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL freeze_rst_resume k=%0d obs=%b want=%b", k, obs_a, exp);
            end
        end
    endtask

    // Reset asserted between edges clears immediately; counting restarts from zero.
    task automatic test_async_reset();
        logic [6:0] exp;
        restart_from_reset();
        repeat (37) @(negedge clk);
        vectors++;
        if (obs_a !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL async_pre obs=%b want=%b", obs_a, {1'b1, 1'b0, 1'b0, 4'd3});
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs_a !== 7'd0) begin
            errors++;
            $display("FAIL async_clear obs=%b want=%b", obs_a, 7'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            exp = (e == 10) ? {1'b1, 1'b0, 1'b1, 4'd1} : 7'd0;
            vectors++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL async_after edge=%0d obs=%b want=%b", e, obs_a, exp);
            end
        end
    endtask

    // Closed loop at 4 clocks/s: green 20+1 cycles, yellow 4+1 cycles, no stale flag.
    task automatic test_closed_loop();
        tl_phase_e phase;
        int        len;
        int        want;
        int        phases_done;
        logic      first;
        restart_from_reset();
        phase       = PH_NS_GREEN;
        len         = 0;
        phases_done = 0;
        first       = 1'b0;
        for (int c = 0; c < 400 && phases_done < 8; c++) begin
            @(posedge clk);
            len++;
            if (tl_b.rst_count) begin
                want = phase_uses_long(phase) ? 21 : 5;
                vectors++;
                if (len !== want) begin
                    errors++;
                    $display("FAIL loop_phase_len phase=%0d got=%0d want=%0d", phase, len, want);
                end
                phase = tl_phase_e'(phase + 2'd1);
                len   = 0;
                first = 1'b1;
                phases_done++;
            end
            @(negedge clk);
            if (first) begin
                vectors++;
                if ({tl_b.one_sec_timer, tl_b.five_sec_timer} !== 2'b00) begin
                    errors++;
                    $display("FAIL loop_stale_flag phase=%0d flags=%b want=%b",
                             phase, {tl_b.one_sec_timer, tl_b.five_sec_timer}, 2'b00);
                end
                first = 1'b0;
            end
            tl_b.rst_count = phase_uses_long(phase) ? tl_b.five_sec_timer : tl_b.one_sec_timer;
        end
        tl_b.rst_count = 1'b0;
        vectors++;
        if (phases_done !== 8) begin
            errors++;
            $display("FAIL loop_budget phases=%0d want=%0d", phases_done, 8);
        end
    endtask

    initial begin
        tl_a.rst_count = 1'b0;
        tl_a.count_en  = 1'b1;
        tl_b.rst_count = 1'b0;
        tl_b.count_en  = 1'b1;
        test_reset();
        test_free_run();
        test_restart();
        test_collision();
        test_freeze();
        test_async_reset();
        test_closed_loop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
